// File: rtl/vanilla_scoreboard_category_tracker_if.sv
// Event bundle feeding the scoreboard category tracker: issue, clear, dependency stall and stats clear.
// No latency of its own; every signal is a single-cycle strobe sampled on the tracker's clock.
// No backpressure: the tracker accepts every event in the cycle it is presented.
interface vanilla_scoreboard_category_tracker_if #(
    parameter int reg_addr_width_p = 5,
    parameter int cat_width_p      = 3
);
    logic                        issue_v_i;
    logic [reg_addr_width_p-1:0] issue_id_i;
    logic [cat_width_p-1:0]      issue_cat_i;
    logic                        clear_v_i;
    logic [reg_addr_width_p-1:0] clear_id_i;
    logic                        stall_dep_v_i;
    logic [reg_addr_width_p-1:0] stall_dep_id_i;
    logic                        clear_stats_i;

    modport master (
        output issue_v_i, issue_id_i, issue_cat_i,
        output clear_v_i, clear_id_i,
        output stall_dep_v_i, stall_dep_id_i,
        output clear_stats_i
    );

    modport slave (
        input issue_v_i, issue_id_i, issue_cat_i,
        input clear_v_i, clear_id_i,
        input stall_dep_v_i, stall_dep_id_i,
        input clear_stats_i
    );
endinterface

// File: rtl/vanilla_scoreboard_category_tracker.sv
// Tracks pending long-latency register writes by category, attributes dependency stalls, flags protocol errors.
// Latency: one cycle; an event in cycle N is visible on the registered outputs in cycle N+1.
// No backpressure: every event is absorbed in its cycle; counters saturate instead of wrapping.
module vanilla_scoreboard_category_tracker #(
    parameter int  reg_els_p        = 32,
    parameter int  reg_addr_width_p = 5,
    parameter int  num_cat_p        = 8,
    parameter int  ignore_r0_p      = 1,
    parameter int  ctr_width_p      = 32,
    localparam int cat_width_lp     = (num_cat_p > 1) ? $clog2(num_cat_p) : 1
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    vanilla_scoreboard_category_tracker_if.slave ev,
    output logic [reg_els_p-1:0]               pending_o,
    output logic [reg_els_p*cat_width_lp-1:0]  cat_o,
    output logic [reg_addr_width_p:0]          outstanding_o,
    output logic [num_cat_p*ctr_width_p-1:0]   issue_cnt_o,
    output logic [num_cat_p*ctr_width_p-1:0]   stall_cnt_o,
    output logic [ctr_width_p-1:0]             stall_unattr_o,
    output logic                               err_double_issue_o,
    output logic                               err_spurious_clear_o
);
    logic                    issue_ok;
    logic                    clear_ok;
    logic                    same_reg;
    logic                    cat_ok;
    logic                    stall_hit;
    logic                    stall_cat_ok;
    logic [cat_width_lp-1:0] stall_cat;
    logic [reg_els_p-1:0]    pending_n;
    logic [reg_addr_width_p:0] pop_n;

    // Register 0 of the int file is hardwired, so its events are dropped before anything else sees them.
    assign issue_ok  = ev.issue_v_i & ~((ignore_r0_p != 0) && (ev.issue_id_i == '0));
    assign clear_ok  = ev.clear_v_i & ~((ignore_r0_p != 0) && (ev.clear_id_i == '0));
    assign same_reg  = clear_ok && (ev.clear_id_i == ev.issue_id_i);
    assign stall_hit = ev.stall_dep_v_i & pending_o[ev.stall_dep_id_i];
    assign stall_cat = cat_o[ev.stall_dep_id_i*cat_width_lp +: cat_width_lp];

    // Category indices past num_cat_p only exist when num_cat_p is not a power of two.
    // A pending register holding such a category is stalled on without bumping any counter.
    if (num_cat_p == (1 << cat_width_lp)) begin : g_cat_full
        assign cat_ok       = 1'b1;
        assign stall_cat_ok = 1'b1;
    end else begin : g_cat_part
        assign cat_ok       = (32'(ev.issue_cat_i) < num_cat_p);
        assign stall_cat_ok = (32'(stall_cat) < num_cat_p);
    end

    // Next pending vector: the clear retires the old write first, so a same-register issue wins.
    always_comb begin
        pending_n = pending_o;
        if (clear_ok) pending_n[ev.clear_id_i] = 1'b0;
        if (issue_ok) pending_n[ev.issue_id_i] = 1'b1;
    end

    // Population count of the next-state pending vector.
    always_comb begin
        pop_n = '0;
        for (int i = 0; i < reg_els_p; i++) begin
            pop_n = pop_n + (reg_addr_width_p+1)'(pending_n[i]);
        end
    end

    // Pending/category state and sticky protocol error flags.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_o            <= '0;
            cat_o                <= '0;
            outstanding_o        <= '0;
            err_double_issue_o   <= 1'b0;
            err_spurious_clear_o <= 1'b0;
        end else begin
            pending_o     <= pending_n;
            outstanding_o <= pop_n;
            if (issue_ok) begin
                cat_o[ev.issue_id_i*cat_width_lp +: cat_width_lp] <= ev.issue_cat_i;
            end
            if (clear_ok && !pending_o[ev.clear_id_i]) begin
                err_spurious_clear_o <= 1'b1;
            end
            if (issue_ok && ((pending_o[ev.issue_id_i] && !same_reg) || !cat_ok)) begin
                err_double_issue_o <= 1'b1;
            end
        end
    end

    // Saturating statistics counters; clear_stats_i overrides any same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (reset_i || ev.clear_stats_i) begin
            issue_cnt_o    <= '0;
            stall_cnt_o    <= '0;
            stall_unattr_o <= '0;
        end else begin
            for (int k = 0; k < num_cat_p; k++) begin
                if (issue_ok && cat_ok && (ev.issue_cat_i == cat_width_lp'(k))
                    && !(&issue_cnt_o[k*ctr_width_p +: ctr_width_p])) begin
                    issue_cnt_o[k*ctr_width_p +: ctr_width_p] <=
                        issue_cnt_o[k*ctr_width_p +: ctr_width_p] + ctr_width_p'(1);
                end
                if (stall_hit && stall_cat_ok && (stall_cat == cat_width_lp'(k))
                    && !(&stall_cnt_o[k*ctr_width_p +: ctr_width_p])) begin
                    stall_cnt_o[k*ctr_width_p +: ctr_width_p] <=
                        stall_cnt_o[k*ctr_width_p +: ctr_width_p] + ctr_width_p'(1);
                end
            end
            if (ev.stall_dep_v_i && !stall_hit && !(&stall_unattr_o)) begin
                stall_unattr_o <= stall_unattr_o + ctr_width_p'(1);
            end
        end
    end
endmodule

// File: doc/vanilla_scoreboard_category_tracker.md
Name: vanilla_scoreboard_category_tracker

Overview:
- Parametrised bench-side tracker of outstanding long-latency register writes for one vanilla core register file (int or float, chosen by parameter).
- Each pending register records the category that set it (idiv, fdiv/fsqrt, remote DRAM/global/group load, AMO, seq load, ...) as an encoded index, not as fixed struct bits.
- Attributes every dependency-stall cycle to the category of the blocking register.
- Flags scoreboard protocol violations; feeds the core profiler and end-of-test checkers.

Parameters:
- reg_els_p, 32, number of architectural registers tracked.
- reg_addr_width_p, 5, register index width; must equal clog2(reg_els_p).
- num_cat_p, 8, number of categories; category index width is cat_width_lp = clog2(num_cat_p) (min 1).
- ignore_r0_p, 1, 1 = register 0 is hardwired (int RF), so issue/clear to 0 is dropped; 0 = float RF, register 0 is tracked.
- ctr_width_p, 32, width of all statistics counters.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, synchronous, active-high.
- issue_v_i  in  1  a tracked op leaves ID this cycle; caller gates with ~stall_id & ~stall_all & ~flush.
- issue_id_i  in  reg_addr_width_p  destination register.
- issue_cat_i  in  cat_width_lp  category of the issuing op.
- clear_v_i  in  1  scoreboard clear (writeback) this cycle.
- clear_id_i  in  reg_addr_width_p  register being cleared.
- stall_dep_v_i  in  1  ID stalled on a register dependency this cycle.
- stall_dep_id_i  in  reg_addr_width_p  register that blocks ID.
- clear_stats_i  in  1  zero all statistics counters.
- pending_o  out  reg_els_p  per-register pending bit.
- cat_o  out  reg_els_p*cat_width_lp  per-register category; reg i occupies bits [i*cat_width_lp +: cat_width_lp]; valid only when pending_o[i].
- outstanding_o  out  reg_addr_width_p+1  population count of pending_o.
- issue_cnt_o  out  num_cat_p*ctr_width_p  issues per category.
- stall_cnt_o  out  num_cat_p*ctr_width_p  attributed stall cycles per category.
- stall_unattr_o  out  ctr_width_p  stall cycles whose blocking register was not pending.
- err_double_issue_o  out  1  sticky: issue to an already-pending register with no same-cycle clear of it.
- err_spurious_clear_o  out  1  sticky: clear of a non-pending register.

Behaviour:
- Reset: all pending bits, categories, counters, outstanding_o and both error flags are 0. Reset mid-operation discards all pending state with no error flagged.
- All outputs are registered. An event in cycle N is visible on outputs in cycle N+1.
- Issue on reg r (not dropped): pending[r] <= 1, cat[r] <= issue_cat_i, issue_cnt[issue_cat_i] += 1.
- Clear on reg r: pending[r] <= 0. cat[r] is held, don't-care.
- Issue and clear to the same r in the same cycle: the clear retires the old write and the issue wins. Result: pending=1, new category, no error flags.
- Issue and clear to different registers: both take effect.
- ignore_r0_p=1: issue or clear with id 0 is a no-op. It updates no counter and raises no error.
- Double issue: issue to a pending r without a same-cycle clear of r sets err_double_issue_o. The new category overwrites the old one.
- Spurious clear: clear to a non-pending r (after r0 filtering) sets err_spurious_clear_o. State is unchanged.
- Stall attribution, evaluated on current-cycle registered state (before this cycle's issue/clear):
  - stall_dep_v_i and pending[stall_dep_id_i]: stall_cnt[cat[stall_dep_id_i]] += 1.
  - Otherwise, if stall_dep_v_i: stall_unattr += 1.
- Counter arithmetic: every counter saturates at 2^ctr_width_p-1 and never wraps.
- clear_stats_i zeros issue_cnt, stall_cnt and stall_unattr. It takes priority over a same-cycle increment, so the result is 0. It does not affect pending, cat or the error flags.
- outstanding_o is the registered popcount of the next-state pending vector.
- Error flags clear only on reset.
- issue_cat_i >= num_cat_p (non-power-of-2 num_cat_p): the issue updates no counter and sets err_double_issue_o as a protocol error. pending is still set.

Test Plan:
- Reset, then issue r5 cat 2, and 10 cycles later clear r5 -> pending_o[5]=1 and cat 2 from the cycle after issue; issue_cnt[2]=1; outstanding_o 1 then 0; no errors.
- Issue r7 cat 3, then stall_dep_v_i on r7 for 6 cycles, then clear -> stall_cnt[3]=6; stall_unattr_o=0.
- Issue and clear r9 in the same cycle (r9 pending, old cat 1, new cat 4) -> pending_o[9]=1, cat 4, no errors. Separately, issue to pending r9 alone -> err_double_issue_o=1, cat overwritten.
- ignore_r0_p=1: issue and clear r0 -> nothing changes, no error. ignore_r0_p=0: issue r0 cat 0 -> pending_o[0]=1. Clear of idle r12 -> err_spurious_clear_o=1.
- ctr_width_p=4: hold a stall on pending cat-1 reg for 20 cycles -> stall_cnt[1]=15 (saturated). Then assert clear_stats_i during a stall cycle -> 0 on the next cycle.
- Fill all 31 int regs (ignore_r0_p=1) with mixed categories, then assert reset_i mid-stream -> all outputs 0 on the next cycle; later clears report spurious.
